// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared pipeline constants, fetch-buffer entry type and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_if
// Description : Instruction-memory request/response bus of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if;
    import pipeline_pkg::*;

    logic               imem_req;
    logic [31:0]        imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
    modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface
`default_nettype wire

// File: rtl/if_fifo.sv
`default_nettype none
// ============================================================================
// Module      : if_fifo
// Description : Small synchronous fetch buffer with flush; head read from regs.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fifo
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         flush,
    input  wire logic         push,
    input  wire logic         pop,
    input  wire fetch_entry_t din,
    output fetch_entry_t      dout,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (push)  r_wr <= next_ptr(r_wr);
            if (w_pop) r_rd <= next_ptr(r_rd);
            r_count <= r_count + CNT_W'(push) - CNT_W'(w_pop);
        end
    end

    // Payload needs no reset: it is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wr] <= din;
    end

    assign dout  = r_mem[r_rd];
    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction fetch stage with prefetch buffer and branch drop.
//               Macro IF_PREFETCH_EN selects a 2-entry buffer (else 1 entry).
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          freeze,
    input  wire logic          Branch_taken,
    input  wire logic [31:0]   Branch_Address,
    if_stage_if.master         imem,
    output logic [31:0]        PC,
    output logic [INSTR_W-1:0] Instruction,
    output logic               valid
);

`ifdef IF_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_addr;
    logic             r_req;
    logic             r_drop;

    logic             w_ack;
    logic             w_push;
    logic             w_pop;
    logic             w_req_done;
    logic             w_issue;
    logic             w_full;
    logic             w_empty;
    logic [31:0]      w_pc_next;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_next;
    fetch_entry_t     w_din;
    fetch_entry_t     w_head;

    // A stray ack with nothing outstanding (e.g. after reset) is ignored.
    assign w_ack      = r_req && imem.imem_ack;
    assign w_push     = w_ack && !r_drop && !Branch_taken && (!w_full || w_pop);
    assign w_pop      = !w_empty && !freeze && !Branch_taken;
    assign w_req_done = !r_req || imem.imem_ack;
    assign w_din      = '{pc: r_addr + PC_INC, instr: imem.imem_rdata};

    always_comb begin
        w_pc_next    = r_fetch_pc;
        w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
        if (Branch_taken) begin
            w_pc_next    = word_align(Branch_Address);
            w_count_next = '0;
        end else if (w_push) begin
            w_pc_next    = r_fetch_pc + PC_INC;
        end
    end

    // A new request reserves a slot, so it is only issued if one stays free.
    assign w_issue = w_req_done && (w_count_next < CNT_W'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
            r_req      <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_fetch_pc <= w_pc_next;
            if (w_ack)
                r_drop <= 1'b0;
            else if (Branch_taken && r_req)
                r_drop <= 1'b1;
            if (w_req_done) begin
                r_req <= w_issue;
                if (w_issue) r_addr <= w_pc_next;
            end
        end
    end

    if_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (Branch_taken),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_addr;
    assign valid          = !w_empty;
    assign PC             = valid ? w_head.pc    : 32'h0;
    assign Instruction    = valid ? w_head.instr : '0;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed + random bench for if_stage against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

`ifdef IF_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        br;
    logic [31:0] baddr;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        vld;

    if_stage_if bus ();

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .Branch_taken   (br),
        .Branch_Address (baddr),
        .imem           (bus),
        .PC             (pc),
        .Instruction    (ins),
        .valid          (vld)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: presented-instruction queue plus the fetch bookkeeping.
    ent_t        mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_addr;
    logic        m_out;
    logic        m_drop;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hE000_0001 + (a >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc  = 32'h0;
        m_addr = 32'h0;
        m_out  = 1'b0;
        m_drop = 1'b0;
    endtask

    task automatic model_step(input logic f, input logic b, input logic [31:0] ba,
                              input logic a, input logic [31:0] rd);
        logic acked;
        logic keep;
        acked = m_out && a;
        keep  = acked && !m_drop && !b;
        if (b) begin
            mq.delete();
            m_fpc = {ba[31:2], 2'b00};
        end else begin
            if (mq.size() != 0 && !f) void'(mq.pop_front());
            if (keep) begin
                mq.push_back('{pc: m_addr + 32'd4, ins: rd});
                m_fpc = m_fpc + 32'd4;
            end
        end
        if (acked)
            m_drop = 1'b0;
        else if (b && m_out)
            m_drop = 1'b1;
        if (!m_out || acked) begin
            m_out = (mq.size() < DEPTH);
            if (m_out) m_addr = m_fpc;
        end
    endtask

    task automatic check_all();
        ent_t h;
        h = '0;
        if (mq.size() != 0) h = mq[0];
        chk("imem_req",    {31'b0, bus.imem_req}, {31'b0, m_out});
        chk("imem_addr",   bus.imem_addr, m_addr);
        chk("valid",       {31'b0, vld}, {31'b0, (mq.size() != 0)});
        chk("PC",          pc, h.pc);
        chk("Instruction", ins, h.ins);
    endtask

    task automatic cycle(input logic f, input logic b, input logic [31:0] ba, input logic a);
        logic [31:0] rd;
        rd = m_out ? mem_word(m_addr) : $urandom;
        freeze         = f;
        br             = b;
        baddr          = ba;
        bus.imem_ack   = a;
        bus.imem_rdata = rd;
        model_step(f, b, ba, a, rd);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        ent_t        hold;
        logic        f;
        logic        b;
        logic        a;
        logic [31:0] ba;

        rst = 1'b0; freeze = 1'b0; br = 1'b0; baddr = 32'h0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();

        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("first_req",  {31'b0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0);

        // Zero-wait stream
        cycle(1'b0, 1'b0, 32'h0, m_out);
`ifdef IF_PREFETCH_EN
        for (int k = 1; k <= 3; k++) begin
            chk("stream_valid", {31'b0, vld}, 32'd1);
            chk("stream_pc",    pc, 32'(4 * k));
            chk("stream_instr", ins, 32'hE000_0000 + 32'(k));
            cycle(1'b0, 1'b0, 32'h0, m_out);
        end
`else
        repeat (6) cycle(1'b0, 1'b0, 32'h0, m_out);
`endif

        // Freeze: fill the buffer, then hold it
        repeat (3) cycle(1'b1, 1'b0, 32'h0, m_out);
        hold = '0;
        if (mq.size() != 0) hold = mq[0];
        repeat (3) begin
            cycle(1'b1, 1'b0, 32'h0, m_out);
            chk("frz_req", {31'b0, bus.imem_req}, 32'd0);
            chk("frz_pc",  pc, hold.pc);
        end
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b0);

        // Mid-run reset with a request left hanging, then a stray ack
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_req",   {31'b0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'b0, vld}, 32'd0);
        chk("rst_addr",  bus.imem_addr, 32'h0);
        bus.imem_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rel_req",  {31'b0, bus.imem_req}, 32'd1);
        chk("rel_addr", bus.imem_addr, 32'h0);

        // Branch while the fetch of 0x8 is outstanding
        for (int i = 0; i < 20 && !(m_out && m_addr == 32'h8); i++)
            cycle(1'b0, 1'b0, 32'h0, m_out);
        chk("pre_br_addr", bus.imem_addr, 32'h8);
        cycle(1'b0, 1'b1, 32'h100, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("drop_req",  {31'b0, bus.imem_req}, 32'd1);
        chk("drop_addr", bus.imem_addr, 32'h100);
        for (int i = 0; i < 10 && !vld; i++)
            cycle(1'b0, 1'b0, 32'h0, m_out);
        chk("br_valid", {31'b0, vld}, 32'd1);
        chk("br_pc",    pc, 32'h104);

        // Branch coinciding with ack and freeze
        for (int i = 0; i < 10 && !(m_out && (mq.size() != 0 || DEPTH == 1)); i++)
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h200, 1'b1);
        chk("bra_valid", {31'b0, vld}, 32'd0);
        chk("bra_req",   {31'b0, bus.imem_req}, 32'd1);
        chk("bra_addr",  bus.imem_addr, 32'h200);

        // Address wrap
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, m_out);
        chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 10 && !vld; i++)
            cycle(1'b0, 1'b0, 32'h0, m_out);
        chk("wrap_pc", pc, 32'h0);
        for (int i = 0; i < 10 && !(bus.imem_req && bus.imem_addr != 32'hFFFF_FFFC); i++)
            cycle(1'b0, 1'b0, 32'h0, m_out);
        chk("wrap_addr", bus.imem_addr, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            f  = ($urandom % 4) == 0;
            b  = ($urandom % 12) == 0;
            ba = $urandom_range(0, 255) << 2;
            a  = m_out ? (($urandom % 3) != 0) : (($urandom % 8) == 0);
            cycle(f, b, ba, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
